mux_nway_arb: RTL and testbench
===============================

MUX_NWAY_ARB -- requirements
Module: mux_nway_arb

Interface
REQ-001 Parameter WIDTH, default 16: data bits per channel, legal range 1..64.
REQ-002 Parameter N, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter SW, default $clog2(N): select and grant-id width.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Port in_data, input, N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, N: per-channel valid.
REQ-008 Port in_ready, output, N: per-channel ready.
REQ-009 Port sel, input, SW: fixed-mode channel select.
REQ-010 Port rr_en, input, 1: 0 = fixed select mode; 1 = round-robin arbitration mode.
REQ-011 Port out_data, output, WIDTH: registered selected data.
REQ-012 Port out_id, output, SW: channel index that supplied out_data.
REQ-013 Port out_valid, output, 1: out_data/out_id hold a beat.
REQ-014 Port out_ready, input, 1: downstream accepts the beat.
REQ-015 Port beat_cnt, output, 16: count of output transfers, wraps modulo 2^16.

Function
REQ-016 load_en = !out_valid || out_ready; the output register SHALL load only when load_en is 1.
REQ-017 Fixed mode: chosen channel = sel when sel < N; when sel >= N, no channel is chosen.
REQ-018 Round-robin mode: chosen channel = first k with in_valid[k]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-019 in_ready[k] SHALL be 1 iff load_en=1 and k is the chosen channel; all other bits SHALL be 0.
REQ-020 in_ready SHALL be combinational from load_en, sel, rr_en, ptr and in_valid, with no dependence on out_data.
REQ-021 An input transfer occurs on channel k when in_valid[k] and in_ready[k] are both 1.
REQ-022 On an input transfer, the next cycle SHALL show out_data = channel k data, out_id = k and out_valid = 1. Latency is 1 cycle.
REQ-023 If load_en=1 and no input transfers, out_valid SHALL go to 0 on the next cycle, and out_data/out_id SHALL hold their values.
REQ-024 If load_en=0, out_data, out_id and out_valid SHALL hold.
REQ-025 Full throughput: with out_ready held at 1 and a chosen channel valid every cycle, one beat SHALL transfer per cycle.
REQ-026 A simultaneous output drain and input load in the same cycle SHALL be permitted.
REQ-027 ptr (SW bits) SHALL update only on a round-robin-mode input transfer from channel k, to (k+1) mod N. Wrap: k=N-1 gives ptr=0.
REQ-028 ptr SHALL hold during fixed-mode operation.
REQ-029 An rr_en change SHALL take effect on the same cycle's choice. A beat already in the output register is unaffected.
REQ-030 beat_cnt SHALL increment by 1 on each cycle with out_valid && out_ready, wrapping from 0xFFFF to 0x0000.

Reset
REQ-031 When reset=1 at a clock edge, the following SHALL be cleared: out_valid=0, out_data=0, out_id=0, ptr=0, beat_cnt=0.
REQ-032 in_ready SHALL be forced to 0 while reset=1.
REQ-033 Reset asserted mid-operation SHALL discard any held beat without transferring it downstream.

Structure
REQ-034 A shared package SHALL hold the MODE_FIXED/MODE_RR encodings and the beat counter width constant (16).
REQ-035 The round-robin priority search SHALL be one sub-module, rr_pick. Its inputs are valid vector and ptr; its outputs are a one-hot grant and a grant index.
REQ-036 The output register, ptr and counter SHALL reside in mux_nway_arb.

Verification (N=4, WIDTH=16)
REQ-037 Fixed mode: rr_en=0, sel=2, in_valid=4'b1111, ch2=0xBEEF, out_ready=1 -> next cycle out_data=0xBEEF, out_id=2, out_valid=1; in_ready=4'b0100.
REQ-038 Invalid select: N=3, sel=3, all valid -> in_ready=0 and out_valid falls to 0 after draining.
REQ-039 Round-robin fairness: rr_en=1, all valid, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 and beat_cnt=8.
REQ-040 Back-pressure: out_valid=1 with out_data=0x1234 and out_ready=0 for 5 cycles -> out_data holds 0x1234, in_ready=0, beat_cnt unchanged.
REQ-041 Round-robin skip and wrap: ptr=3, in_valid=4'b0010 -> ch1 granted, then ptr=2.
REQ-042 Reset mid-beat: out_valid=1 and beat_cnt=5, reset pulsed 1 cycle -> out_valid=0, beat_cnt=0, ptr=0; the next grant in round-robin mode starts from ch0.

Source files
------------

// File: rtl/mux_nway_arb_pkg.sv
// Shared encodings and constants for the N-way channel multiplexer/arbiter.
// The beat counter increment lives here so every user wraps the same way.
package mux_nway_arb_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int BEAT_CNT_W = 16;

   // Modulo-2^BEAT_CNT_W increment; the natural overflow gives the wrap.
   function automatic logic [BEAT_CNT_W-1:0] cnt_inc(input logic [BEAT_CNT_W-1:0] cnt);
      return cnt + BEAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/mux_nway_arb_rr_pick.sv
// Round-robin priority search: first valid channel at or after ptr, wrapping.
// Produces a one-hot grant and the matching index; both are zero when nothing is valid.
module rr_pick
   import mux_nway_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_idx
);

   localparam logic [SW:0] N_L = (SW+1)'(N);

   logic [N-1:0]  rot_s;
   logic [SW:0]   sum_s;
   logic [SW-1:0] idx_s;
   logic          found_s;

   // Rotating by ptr puts the highest-priority channel at bit 0.
   assign rot_s = N'({valid, valid} >> ptr);

   // Fixed-priority scan of the rotated vector, mapped back to a channel index.
   always_comb begin
      found_s = 1'b0;
      idx_s   = '0;
      sum_s   = '0;
      for (int j = 0; j < N; j++) begin
         sum_s = {1'b0, ptr} + (SW+1)'(j);
         if (!found_s && rot_s[j]) begin
            found_s = 1'b1;
            idx_s   = (sum_s >= N_L) ? SW'(sum_s - N_L) : SW'(sum_s);
         end else begin
            found_s = found_s;
         end
      end
   end

   // One-hot expansion of the winning index.
   always_comb begin
      grant = '0;
      for (int k = 0; k < N; k++) begin
         grant[k] = found_s && (idx_s == SW'(k));
      end
      grant_idx = idx_s;
   end

endmodule

// File: rtl/mux_nway_arb.sv
// N-way channel multiplexer with fixed-select or round-robin arbitration
// feeding a single registered valid/ready output stage and a beat counter.
module mux_nway_arb
   import mux_nway_arb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SW    = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N*WIDTH-1:0]    in_data,
   input  logic [N-1:0]          in_valid,
   output logic [N-1:0]          in_ready,
   input  logic [SW-1:0]         sel,
   input  logic                  rr_en,
   output logic [WIDTH-1:0]      out_data,
   output logic [SW-1:0]         out_id,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BEAT_CNT_W-1:0] beat_cnt
);

   localparam logic [SW:0] N_L = (SW+1)'(N);

   logic                  load_en_s;
   logic                  rr_mode_s;
   logic                  sel_ok_s;
   logic                  xfer_s;
   logic [N-1:0]          rr_grant_s;
   logic [N-1:0]          fix_grant_s;
   logic [N-1:0]          chosen_s;
   logic [SW-1:0]         rr_idx_s;
   logic [SW-1:0]         chosen_idx_s;
   logic [SW-1:0]         ptr_next_s;
   logic [WIDTH-1:0]      pick_data_s;
   logic [SW-1:0]         ptr_r;
   logic [WIDTH-1:0]      out_data_r;
   logic [SW-1:0]         out_id_r;
   logic                  out_valid_r;
   logic [BEAT_CNT_W-1:0] beat_cnt_r;

   assign load_en_s = !out_valid_r || out_ready;
   assign rr_mode_s = (mode_e'(rr_en) == MODE_RR);

   rr_pick #(
      .N  (N),
      .SW (SW)
   ) u_rr_pick (
      .valid     (in_valid),
      .ptr       (ptr_r),
      .grant     (rr_grant_s),
      .grant_idx (rr_idx_s)
   );

   // Channel choice for the current mode; an out-of-range select chooses nothing.
   always_comb begin
      sel_ok_s    = ({1'b0, sel} < N_L);
      fix_grant_s = '0;
      for (int k = 0; k < N; k++) begin
         fix_grant_s[k] = sel_ok_s && (sel == SW'(k));
      end
      if (rr_mode_s) begin
         chosen_s     = rr_grant_s;
         chosen_idx_s = rr_idx_s;
      end else begin
         chosen_s     = fix_grant_s;
         chosen_idx_s = sel;
      end
   end

   // Ready is offered only to the chosen channel, and never during reset.
   always_comb begin
      if (reset) begin
         in_ready = '0;
      end else if (load_en_s) begin
         in_ready = chosen_s;
      end else begin
         in_ready = '0;
      end
   end

   assign xfer_s = |(in_valid & in_ready);

   // AND-OR data mux keyed on the one-hot choice.
   always_comb begin
      pick_data_s = '0;
      for (int k = 0; k < N; k++) begin
         pick_data_s = pick_data_s | ({WIDTH{chosen_s[k]}} & in_data[k*WIDTH +: WIDTH]);
      end
   end

   assign ptr_next_s = (chosen_idx_s == SW'(N-1)) ? '0 : chosen_idx_s + SW'(1);

   // Output register, round-robin pointer and beat counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_id_r    <= '0;
         ptr_r       <= '0;
         beat_cnt_r  <= '0;
      end else begin
         if (load_en_s) begin
            out_valid_r <= xfer_s;
            if (xfer_s) begin
               out_data_r <= pick_data_s;
               out_id_r   <= chosen_idx_s;
            end
         end
         if (xfer_s && rr_mode_s) begin
            ptr_r <= ptr_next_s;
         end
         if (out_valid_r && out_ready) begin
            beat_cnt_r <= cnt_inc(beat_cnt_r);
         end
      end
   end

   assign out_data  = out_data_r;
   assign out_id    = out_id_r;
   assign out_valid = out_valid_r;
   assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic checked against
// a transaction-level reference model of the arbiter (N=4), and an N=3 instance.
module tb_mux_nway_arb;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [15:0] ch [4];
   logic [63:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  sel;
   logic        rr_en;
   logic [15:0] out_data;
   logic [1:0]  out_id;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] beat_cnt;

   logic [47:0] d2_in_data;
   logic [2:0]  d2_in_valid;
   logic [2:0]  d2_in_ready;
   logic [1:0]  d2_sel;
   logic        d2_rr_en;
   logic [15:0] d2_out_data;
   logic [1:0]  d2_out_id;
   logic        d2_out_valid;
   logic        d2_out_ready;
   logic [15:0] d2_beat_cnt;

   assign in_data = {ch[3], ch[2], ch[1], ch[0]};

   mux_nway_arb #(.WIDTH(16), .N(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .sel(sel), .rr_en(rr_en), .out_data(out_data),
      .out_id(out_id), .out_valid(out_valid), .out_ready(out_ready), .beat_cnt(beat_cnt)
   );

   mux_nway_arb #(.WIDTH(16), .N(3)) dut3 (
      .clk(clk), .reset(reset), .in_data(d2_in_data), .in_valid(d2_in_valid),
      .in_ready(d2_in_ready), .sel(d2_sel), .rr_en(d2_rr_en), .out_data(d2_out_data),
      .out_id(d2_out_id), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
      .beat_cnt(d2_beat_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state (transaction level)
   logic        m_ov;
   logic [15:0] m_od;
   int          m_oid;
   int          m_ptr;
   int          m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Chosen channel from the rules: sel in fixed mode, else first valid from ptr onward.
   function automatic int choose(input logic rr, input logic [1:0] s, input logic [3:0] v,
                                 input int p);
      if (!rr) return (int'(s) < 4) ? int'(s) : -1;
      for (int i = 0; i < 4; i++) begin
         if (v[(p + i) % 4]) return (p + i) % 4;
      end
      return -1;
   endfunction

   task automatic model_clear();
      m_ov = 1'b0; m_od = 16'h0000; m_oid = 0; m_ptr = 0; m_cnt = 0;
   endtask

   // One clock: compare DUT to model at the falling edge, then advance the model.
   task automatic cycle();
      int c;
      logic ld;
      logic [3:0] er;
      @(negedge clk);
      ld = !m_ov || out_ready;
      c  = choose(rr_en, sel, in_valid, m_ptr);
      er = (!reset && ld && c >= 0) ? (4'b0001 << c) : 4'b0000;
      chk("in_ready",  64'(in_ready),  64'(er));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_data",  64'(out_data),  64'(m_od));
      chk("out_id",    64'(out_id),    64'(m_oid));
      chk("beat_cnt",  64'(beat_cnt),  64'(m_cnt));
      if (reset) begin
         model_clear();
      end else begin
         if (m_ov && out_ready) m_cnt = (m_cnt + 1) % 65536;
         if (ld) begin
            if (c >= 0 && in_valid[c]) begin
               m_ov = 1'b1; m_od = ch[c]; m_oid = c;
               if (rr_en) m_ptr = (c + 1) % 4;
            end else begin
               m_ov = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; rr_en = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) ch[k] = 16'h1000 + 16'(k);
      d2_in_data = 48'h0; d2_in_valid = 3'b000; d2_sel = 2'd0; d2_rr_en = 1'b0;
      d2_out_ready = 1'b1;
      @(posedge clk); #1;
      model_clear();
      cycle();
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      reset = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data",  64'(out_data),  64'h0);
      chk("rst_beat_cnt",  64'(beat_cnt),  64'h0);

      // Fixed select of channel 2
      ch[0] = 16'h1111; ch[1] = 16'h2222; ch[2] = 16'hBEEF; ch[3] = 16'h4444;
      sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
      #1;
      chk("fix_in_ready", 64'(in_ready), 64'h4);
      cycle();
      chk("fix_out_data",  64'(out_data),  64'hBEEF);
      chk("fix_out_id",    64'(out_id),    64'h2);
      chk("fix_out_valid", 64'(out_valid), 64'h1);

      // Round-robin fairness from a fresh reset
      reset = 1'b1; cycle(); reset = 1'b0;
      rr_en = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rr_seq_id", 64'(out_id), 64'(i % 4));
      end
      in_valid = 4'b0000;
      cycle();
      chk("rr_beat_cnt", 64'(beat_cnt), 64'd8);
      chk("rr_drained",  64'(out_valid), 64'h0);

      // Back-pressure holds the beat
      rr_en = 1'b0; sel = 2'd1; ch[1] = 16'h1234; in_valid = 4'b0010;
      cycle();
      chk("bp_load", 64'(out_data), 64'h1234);
      out_ready = 1'b0; ch[1] = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_data",  64'(out_data), 64'h1234);
         chk("bp_ready", 64'(in_ready), 64'h0);
      end
      chk("bp_beat_cnt", 64'(beat_cnt), 64'd8);
      out_ready = 1'b1; in_valid = 4'b0000;
      cycle();

      // Round-robin skip and wrap: grant ch2 so ptr=3, then only ch1 valid
      rr_en = 1'b1; in_valid = 4'b0100;
      cycle();
      in_valid = 4'b0010;
      #1;
      chk("skip_in_ready", 64'(in_ready), 64'h2);
      cycle();
      chk("skip_out_id", 64'(out_id), 64'h1);
      in_valid = 4'b1111;
      #1;
      chk("ptr_after_wrap", 64'(in_ready), 64'h4);
      cycle();

      // Reset mid-beat
      reset = 1'b1; cycle(); reset = 1'b0;
      rr_en = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      chk("mid_beat_cnt5", 64'(beat_cnt), 64'd5);
      out_ready = 1'b0;
      reset = 1'b1; cycle(); reset = 1'b0;
      chk("mid_out_valid", 64'(out_valid), 64'h0);
      chk("mid_beat_cnt0", 64'(beat_cnt), 64'h0);
      out_ready = 1'b1;
      #1;
      chk("mid_first_grant", 64'(in_ready), 64'h1);
      cycle();
      chk("mid_out_id", 64'(out_id), 64'h0);

      // N=3 instance: out-of-range select chooses nothing
      d2_in_data = {16'hCCCC, 16'hBBBB, 16'hAAAA}; d2_sel = 2'd1; d2_in_valid = 3'b111;
      cycle();
      chk("n3_load_valid", 64'(d2_out_valid), 64'h1);
      chk("n3_load_id",    64'(d2_out_id),    64'h1);
      chk("n3_load_data",  64'(d2_out_data),  64'hBBBB);
      d2_sel = 2'd3;
      #1;
      chk("n3_bad_sel_ready", 64'(d2_in_ready), 64'h0);
      cycle();
      chk("n3_drain_valid", 64'(d2_out_valid), 64'h0);
      chk("n3_hold_data",   64'(d2_out_data),  64'hBBBB);
      chk("n3_still_ready", 64'(d2_in_ready),  64'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 4; k++) ch[k] = 16'($urandom);
         in_valid  = 4'($urandom);
         sel       = 2'($urandom);
         rr_en     = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 49) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
